bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 17 +
 rtl/bin2bcd_seq_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 tb/tb_bin2bcd_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Enough decimal digits to hold 2^width - 1 (log10(2) ~= 0.301).
  function automatic int bcd_digits(input int width);
    return (width * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, ready/valid on both sides.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WIDTH-1:0]                       in_bin,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [bcd_digits(WIDTH)*DIGIT_W-1:0]   out_bcd,
  output logic                                   out_neg
);

  localparam int DIGITS = bcd_digits(WIDTH);
  localparam int BCD_W  = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   acc_q, acc_d, acc_adj;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               oneg_q, oneg_d;
  logic               in_neg;

  assign in_neg = SIGNED_EN && in_bin[WIDTH-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_digit u_add3 (
      .d_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .d_o (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    oneg_d  = oneg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Negation wraps -2^(WIDTH-1) onto itself, which is the right unsigned magnitude.
          mag_d   = in_neg ? (~in_bin) + WIDTH'(1) : in_bin;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          neg_d   = in_neg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Top bit of the corrected accumulator is always 0 when DIGITS is sized right.
        acc_d = BCD_W'({acc_adj, mag_q[WIDTH-1]});
        mag_d = mag_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_d;
          oneg_d  = neg_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mag_q  <= '0;
      acc_q  <= '0;
      bcd_q  <= '0;
      neg_q  <= 1'b0;
      oneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mag_q  <= mag_d;
      acc_q  <= acc_d;
      bcd_q  <= bcd_d;
      neg_q  <= neg_d;
      oneg_q <= oneg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_neg   = oneg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq at 8-bit unsigned/signed, 16-bit and 32-bit.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // a: 8-bit unsigned, s: 8-bit signed, m: 16-bit, w: 32-bit
  logic a_iv, a_ir, a_ov, a_or, a_neg; logic [7:0]  a_bin; logic [11:0] a_bcd;
  logic s_iv, s_ir, s_ov, s_or, s_neg; logic [7:0]  s_bin; logic [11:0] s_bcd;
  logic m_iv, m_ir, m_ov, m_or, m_neg; logic [15:0] m_bin; logic [19:0] m_bcd;
  logic w_iv, w_ir, w_ov, w_or, w_neg; logic [31:0] w_bin; logic [39:0] w_bcd;

  // {neg, 10 BCD digits}
  logic [40:0] q_a[$], q_s[$], q_m[$], q_w[$];
  logic [40:0] exp_v;

  bin2bcd_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_bin(a_bin),
    .out_valid(a_ov), .out_ready(a_or), .out_bcd(a_bcd), .out_neg(a_neg));
  bin2bcd_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .in_bin(s_bin),
    .out_valid(s_ov), .out_ready(s_or), .out_bcd(s_bcd), .out_neg(s_neg));
  bin2bcd_seq #(.WIDTH(16), .SIGNED_EN(1'b0)) u_m (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .in_bin(m_bin),
    .out_valid(m_ov), .out_ready(m_or), .out_bcd(m_bcd), .out_neg(m_neg));
  bin2bcd_seq #(.WIDTH(32), .SIGNED_EN(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w_ir), .in_bin(w_bin),
    .out_valid(w_ov), .out_ready(w_or), .out_bcd(w_bcd), .out_neg(w_neg));

  function automatic logic [39:0] to_bcd(input logic [63:0] v);
    logic [39:0] r;
    logic [63:0] t;
    r = '0;
    t = v;
    for (int k = 0; k < 10; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Push the expected result of every transfer the next edge will accept, then advance.
  task automatic tick();
    if (rst_n) begin
      if (a_iv && a_ir) q_a.push_back({1'b0, to_bcd(64'(a_bin))});
      if (s_iv && s_ir)
        q_s.push_back({s_bin[7], to_bcd(s_bin[7] ? 64'(9'd256 - {1'b0, s_bin}) : 64'(s_bin))});
      if (m_iv && m_ir) q_m.push_back({1'b0, to_bcd(64'(m_bin))});
      if (w_iv && w_ir) q_w.push_back({1'b0, to_bcd(64'(w_bin))});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if ({a_ir, s_ir, m_ir, w_ir} !== 4'b1111) begin errors++;
      $display("FAIL reset_in_ready got=%b exp=1111", {a_ir, s_ir, m_ir, w_ir}); end
    checks++; if ({a_ov, s_ov, m_ov, w_ov} !== 4'b0000) begin errors++;
      $display("FAIL reset_out_valid got=%b exp=0000", {a_ov, s_ov, m_ov, w_ov}); end
    checks++; if ({a_bcd, s_bcd, m_bcd, w_bcd} !== '0) begin errors++;
      $display("FAIL reset_out_bcd got=%h/%h/%h/%h exp=0", a_bcd, s_bcd, m_bcd, w_bcd); end
    checks++; if ({a_neg, s_neg, m_neg, w_neg} !== 4'b0000) begin errors++;
      $display("FAIL reset_out_neg got=%b exp=0000", {a_neg, s_neg, m_neg, w_neg}); end
  endtask

  // 255 accepted on the first edge after reset release; valid exactly 8 edges later.
  task automatic test_latency();
    logic early;
    rst_n = 1'b1; a_bin = 8'd255; a_iv = 1'b1; a_or = 1'b1;
    tick();
    a_iv = 1'b0;
    checks++; if (a_ir !== 1'b0 || q_a.size() != 1) begin errors++;
      $display("FAIL first_edge_accept in_ready=%b queued=%0d exp in_ready=0 queued=1", a_ir, q_a.size()); end
    early = 1'b0;
    for (int k = 1; k < 8; k++) begin tick(); if (a_ov !== 1'b0) early = 1'b1; end
    checks++; if (early) begin errors++; $display("FAIL latency_early got out_valid before T+8 exp none"); end
    tick();
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1 at T+8", a_ov); end
    if (a_ov && a_or && q_a.size() > 0) begin
      exp_v = q_a.pop_front();
      checks++; if ({a_neg, 28'd0, a_bcd} !== exp_v || a_bcd !== 12'h255) begin errors++;
        $display("FAIL latency_bcd got=%h neg=%b exp=%h neg=%b", a_bcd, a_neg, exp_v[11:0], exp_v[40]); end
    end
    tick();
    checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin errors++;
      $display("FAIL latency_ready_back in_ready=%b out_valid=%b exp 1/0 at T+9", a_ir, a_ov); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int got;
    got = 0;
    a_iv = 1'b1; a_bin = 8'd0; a_or = 1'b1;
    for (int k = 0; k < 40 && got < 2; k++) begin
      if (a_iv && a_ir) acc.push_back(cyc);
      if (a_ov && a_or) begin
        got++;
        checks++;
        if (q_a.size() == 0) begin errors++; $display("FAIL b2b_unexpected got=%h exp none", a_bcd); end
        else begin
          exp_v = q_a.pop_front();
          if ({a_neg, 28'd0, a_bcd} !== exp_v) begin errors++;
            $display("FAIL b2b_bcd got=%h exp=%h", a_bcd, exp_v[11:0]); end
        end
      end
      tick();
      if (acc.size() == 1) a_bin = 8'd99;
      if (acc.size() == 2) a_iv = 1'b0;
    end
    a_iv = 1'b0;
    checks++; if (got != 2 || acc.size() != 2) begin errors++;
      $display("FAIL b2b_timeout got=%0d results exp=2", got); end
    else begin
      checks++; if (acc[1] - acc[0] != 10) begin errors++;
        $display("FAIL b2b_spacing got=%0d cycles exp=10", acc[1] - acc[0]); end
    end
  endtask

  task automatic test_wide();
    int m_first, w_first;
    m_first = 0; w_first = 0;
    m_bin = 16'hFFFF; w_bin = 32'hFFFF_FFFF;
    m_iv = 1'b1; w_iv = 1'b1; m_or = 1'b1; w_or = 1'b1;
    tick();
    m_iv = 1'b0; w_iv = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (m_ov && m_first == 0) begin
        m_first = k;
        checks++; if (m_bcd !== 20'h65535 || m_neg !== 1'b0 || q_m.size() == 0) begin errors++;
          $display("FAIL wide16_bcd got=%h neg=%b exp=65535 neg=0", m_bcd, m_neg); end
        if (q_m.size() > 0) void'(q_m.pop_front());
      end
      if (w_ov && w_first == 0) begin
        w_first = k;
        checks++; if (w_bcd !== 40'h42_9496_7295 || w_neg !== 1'b0 || q_w.size() == 0) begin errors++;
          $display("FAIL wide32_bcd got=%h neg=%b exp=4294967295 neg=0", w_bcd, w_neg); end
        if (q_w.size() > 0) void'(q_w.pop_front());
      end
    end
    checks++; if (m_first != 16) begin errors++; $display("FAIL wide16_latency got=%0d exp=16", m_first); end
    checks++; if (w_first != 32) begin errors++; $display("FAIL wide32_latency got=%0d exp=32", w_first); end
  endtask

  task automatic test_signed();
    logic [7:0] vals[5];
    int seen;
    vals = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h9C};
    s_or = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_bin = vals[i]; s_iv = 1'b1;
      tick();
      s_iv = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && !s_ov; k++) tick();
      checks++;
      if (!s_ov || q_s.size() == 0) begin errors++;
        $display("FAIL signed_timeout in=%h out_valid=%b exp=1", vals[i], s_ov); end
      else begin
        exp_v = q_s.pop_front();
        if ({s_neg, 28'd0, s_bcd} !== exp_v) begin errors++;
          $display("FAIL signed_bcd in=%h got=%h neg=%b exp=%h neg=%b", vals[i], s_bcd, s_neg, exp_v[11:0], exp_v[40]); end
        if (i == 0) begin
          checks++; if (s_bcd !== 12'h128 || s_neg !== 1'b1) begin errors++;
            $display("FAIL signed_min got=%h neg=%b exp=128 neg=1", s_bcd, s_neg); end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int a_sent, a_got, w_sent, w_got;
    a_sent = 0; a_got = 0; w_sent = 0; w_got = 0;
    for (int k = 0; k < 3000 && (a_got < 25 || w_got < 6); k++) begin
      a_iv = (a_sent < 25) && ($urandom_range(0, 3) != 0);
      a_bin = 8'($urandom_range(0, 255));
      a_or = ($urandom_range(0, 2) != 0);
      w_iv = (w_sent < 6) && ($urandom_range(0, 1) != 0);
      w_bin = $urandom();
      w_or = ($urandom_range(0, 1) != 0);
      if (a_iv && a_ir) a_sent++;
      if (w_iv && w_ir) w_sent++;
      if (a_ov && a_or) begin
        a_got++; checks++;
        if (q_a.size() == 0) begin errors++; $display("FAIL rand8_unexpected got=%h", a_bcd); end
        else begin
          exp_v = q_a.pop_front();
          if ({a_neg, 28'd0, a_bcd} !== exp_v) begin errors++;
            $display("FAIL rand8_bcd got=%h exp=%h", a_bcd, exp_v[11:0]); end
        end
      end
      if (w_ov && w_or) begin
        w_got++; checks++;
        if (q_w.size() == 0) begin errors++; $display("FAIL rand32_unexpected got=%h", w_bcd); end
        else begin
          exp_v = q_w.pop_front();
          if ({w_neg, w_bcd} !== exp_v) begin errors++;
            $display("FAIL rand32_bcd got=%h exp=%h", w_bcd, exp_v[39:0]); end
        end
      end
      tick();
    end
    a_iv = 1'b0; w_iv = 1'b0;
    checks++; if (a_got < 25 || w_got < 6) begin errors++;
      $display("FAIL rand_timeout got=%0d/%0d exp=25/6", a_got, w_got); end
    a_or = 1'b1; w_or = 1'b1;
    for (int k = 0; k < 40 && (a_ov || w_ov || !a_ir || !w_ir); k++) tick();
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    logic bad;
    a_bin = 8'd200; a_iv = 1'b1; a_or = 1'b0;
    tick();
    a_bin = 8'd7;
    for (int k = 0; k < 20 && !a_ov; k++) tick();
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL bp_timeout out_valid=%b exp=1", a_ov); end
    held = a_bcd; bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (a_ov !== 1'b1 || a_ir !== 1'b0 || a_bcd !== held) bad = 1'b1;
    end
    checks++; if (bad) begin errors++;
      $display("FAIL bp_hold out_valid=%b in_ready=%b bcd=%h exp 1/0/%h", a_ov, a_ir, a_bcd, held); end
    a_or = 1'b1; a_iv = 1'b0;
    checks++;
    if (q_a.size() != 1) begin errors++; $display("FAIL bp_queue got=%0d entries exp=1", q_a.size()); end
    else begin
      exp_v = q_a.pop_front();
      if ({a_neg, 28'd0, a_bcd} !== exp_v) begin errors++;
        $display("FAIL bp_bcd got=%h exp=%h", a_bcd, exp_v[11:0]); end
    end
    tick();
    checks++; if (a_ov !== 1'b0 || a_ir !== 1'b1) begin errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", a_ov, a_ir); end
  endtask

  task automatic test_reset_abort();
    a_bin = 8'd77; a_iv = 1'b1; a_or = 1'b1;
    tick();
    a_iv = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q_a.delete(); q_s.delete(); q_m.delete(); q_w.delete();
    checks++; if (a_ov !== 1'b0 || a_bcd !== 12'h000 || a_ir !== 1'b1) begin errors++;
      $display("FAIL abort_state out_valid=%b bcd=%h in_ready=%b exp 0/000/1", a_ov, a_bcd, a_ir); end
    a_bin = 8'd42; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int k = 0; k < 12 && !a_ov; k++) tick();
    checks++;
    if (!a_ov || q_a.size() != 1) begin errors++;
      $display("FAIL abort_after out_valid=%b queued=%0d exp 1/1", a_ov, q_a.size()); end
    else begin
      exp_v = q_a.pop_front();
      if ({a_neg, 28'd0, a_bcd} !== exp_v || a_bcd !== 12'h042) begin errors++;
        $display("FAIL abort_bcd got=%h exp=042", a_bcd); end
    end
    tick();
  endtask

  initial begin
    a_iv = 0; a_or = 0; a_bin = '0;
    s_iv = 0; s_or = 0; s_bin = '0;
    m_iv = 0; m_or = 0; m_bin = '0;
    w_iv = 0; w_or = 0; w_bin = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_wide();
    test_signed();
    test_random();
    test_backpressure();
    test_reset_abort();
    checks++; if (q_a.size() + q_s.size() + q_m.size() + q_w.size() != 0) begin errors++;
      $display("FAIL leftover_expected got=%0d entries exp=0", q_a.size() + q_s.size() + q_m.size() + q_w.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
